filt_mc: RTL
============

FILT_MC -- requirements
Module: filt_mc

Interface
- REQ-001: Parameter CH, default 4: number of independent filter channels (1..32).
- REQ-002: Parameter LW, default 4: width of the threshold inputs; maximum filter length 2^LW-1 samples.
- REQ-003: Parameter INIT, default 1'b0: value loaded into every y bit on reset.
- REQ-004: The port list SHALL be, clock and reset first:
  - clk, input, 1: single clock, rising edge.
  - rst_n, input, 1: reset, asynchronous and active-low.
  - tick, input, 1: sample strobe; a sample is taken only on edges where tick=1.
  - rise_len, input, LW: consecutive 1-samples needed to assert y.
  - fall_len, input, LW: consecutive 0-samples needed to deassert y.
  - i, input, CH: raw (already synchronised) channel inputs.
  - y, output, CH: filtered levels, registered.
  - rise, output, CH: one-cycle pulse when y[c] goes 0->1 (present only with FILT_MC_EDGE_EN).
  - fall, output, CH: one-cycle pulse when y[c] goes 1->0 (present only with FILT_MC_EDGE_EN).

Function
- REQ-005: Each channel SHALL hold a stable level y[c] and a counter cnt[c] of LW bits; channels SHALL NOT interact.
- REQ-006: On an edge with tick=0, y, cnt and all state SHALL hold, and rise/fall SHALL be 0.
- REQ-007: On an edge with tick=1 and i[c]==y[c], cnt[c] SHALL clear to 0 (glitch discarded).
- REQ-008: On an edge with tick=1 and i[c]!=y[c], cnt[c]+1 SHALL be compared with the active threshold: rise_len if y[c]=0, fall_len if y[c]=1.
- REQ-009: If cnt[c]+1 >= the active threshold, y[c] SHALL toggle on that same edge and cnt[c] SHALL clear to 0. Otherwise cnt[c] SHALL increment.
- REQ-010: Latency: with tick held at 1, y[c] SHALL change on the edge that samples the Nth consecutive differing value (N = threshold). No extra output register stage is allowed.
- REQ-011: A threshold of 0 SHALL behave as 1, so y follows i one sample later.
- REQ-012: cnt SHALL saturate at 2^LW-1 and never wrap.
- REQ-013: Threshold change mid-count SHALL take effect immediately through the >= compare. A counter already at or above the new value SHALL toggle y on the next differing sample.
- REQ-014: rise_len and fall_len SHALL be sampled combinationally every tick. Software SHALL keep them quasi-static.

Reset
- REQ-015: While rst_n=0, asynchronously: y=INIT replicated, cnt=0, rise=0, fall=0.
- REQ-016: Reset assertion mid-count SHALL discard the partial count. After release, counting SHALL restart from 0 against the INIT level.
- REQ-017: The first edge after rst_n release SHALL be a normal sampling edge; no warm-up cycles.

Configuration
- REQ-018: Macro FILT_MC_EDGE_EN defined: rise/fall ports exist. rise[c]/fall[c] SHALL be 1 for exactly the clock cycle after y[c] toggles 0->1 / 1->0; they are registered and aligned with the new y value.
- REQ-019: Macro FILT_MC_EDGE_EN undefined: rise/fall ports and their logic SHALL be absent. All other behaviour SHALL be identical.

Structure
- REQ-020: Package filt_mc_pkg SHALL hold the LW default, the default CH, and a function clamping threshold 0 to 1.
- REQ-021: A per-channel sub-module filt_mc_chan (clk, rst_n, tick, thresholds, i, y, optional edge pulses) SHALL be instantiated CH times by a generate loop.

Verification
- REQ-022: CH=4, rise_len=3, tick=1, i[0]=1 for 3 cycles -> y[0]=1 after the 3rd edge; y[3:1] remain 0.
- REQ-023: rise_len=3, i[1] pattern 1,1,0,1,1 -> y[1] stays 0 throughout (counter cleared by the 0); a 3rd consecutive 1 then sets y[1].
- REQ-024: tick high every 4th cycle, fall_len=2, y[2]=1, i[2]=0 held -> y[2] falls on the 2nd tick edge (cycle 8), not earlier.
- REQ-025: rise_len=0 -> y follows i with 1-cycle delay. rise_len=15 with i high for 20 cycles -> y asserts at cycle 15 and cnt never wraps.
- REQ-026: rst_n pulsed low mid-count (cnt=2 of 3) -> y=INIT immediately; after release, 3 fresh 1-samples are needed to assert y.
- REQ-027: With FILT_MC_EDGE_EN, one full toggle 0->1->0 on channel 0 -> exactly one rise pulse and one fall pulse, each 1 cycle wide, coincident with the y change.

Source files
------------

// File: rtl/filt_mc_pkg.sv
// Shared defaults and helpers for the multi-channel level filter.
// Optional edge pulses are enabled by defining FILT_MC_EDGE_EN.
package filt_mc_pkg;

    localparam int FILT_MC_LW = 4;
    localparam int FILT_MC_CH = 4;

    // A zero threshold is treated as one sample.
    function automatic logic [31:0] thr_clamp(input logic [31:0] t);
        return (t == 32'd0) ? 32'd1 : t;
    endfunction

endpackage

// File: rtl/filt_mc_chan.sv
// One filter channel: run-length debounce of i into a stable level y.
// Edge pulse outputs exist only when FILT_MC_EDGE_EN is defined.
module filt_mc_chan
    import filt_mc_pkg::*;
#(
    parameter int   LW   = FILT_MC_LW,
    parameter logic INIT = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic [LW-1:0] rise_len,
    input  logic [LW-1:0] fall_len,
    input  logic          i,
    output logic          y
`ifdef FILT_MC_EDGE_EN
    ,
    output logic          rise,
    output logic          fall
`endif
);

    logic [LW-1:0] cnt;
    logic [LW-1:0] thr;
    logic [LW:0]   nxt;
    logic          hit;

    // Threshold is chosen by the current level and compared live.
    always_comb begin
        thr = y ? fall_len : rise_len;
        nxt = {1'b0, cnt} + 1'b1;
        hit = 32'(nxt) >= thr_clamp(32'(thr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y   <= INIT;
            cnt <= '0;
`ifdef FILT_MC_EDGE_EN
            rise <= 1'b0;
            fall <= 1'b0;
`endif
        end else begin
`ifdef FILT_MC_EDGE_EN
            rise <= 1'b0;
            fall <= 1'b0;
`endif
            if (tick) begin
                if (i == y) begin
                    cnt <= '0;
                end else if (hit) begin
                    y   <= ~y;
                    cnt <= '0;
`ifdef FILT_MC_EDGE_EN
                    rise <= ~y;
                    fall <= y;
`endif
                end else if (cnt != '1) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/filt_mc.sv
// Multi-channel glitch filter top: CH independent filt_mc_chan instances.
// Define FILT_MC_EDGE_EN to add registered rise/fall pulse outputs.
module filt_mc
    import filt_mc_pkg::*;
#(
    parameter int   CH   = FILT_MC_CH,
    parameter int   LW   = FILT_MC_LW,
    parameter logic INIT = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic [LW-1:0] rise_len,
    input  logic [LW-1:0] fall_len,
    input  logic [CH-1:0] i,
    output logic [CH-1:0] y
`ifdef FILT_MC_EDGE_EN
    ,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall
`endif
);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        filt_mc_chan #(
            .LW   (LW),
            .INIT (INIT)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick),
            .rise_len (rise_len),
            .fall_len (fall_len),
            .i        (i[c]),
            .y        (y[c])
`ifdef FILT_MC_EDGE_EN
            ,
            .rise     (rise[c]),
            .fall     (fall[c])
`endif
        );
    end

endmodule
